pim_port_arbiter: RTL and testbench

- Round-robin scheduler that shares one my_pim macro port (data[39:0], addr[8:0], we, out[7:0]) among NREQ requesters.
- Accepts read/write commands over valid/ready, registers the selected command onto the macro pins and tracks read tags through the macro's fixed read latency.
- Routes each read result back to the requester that issued it.
- Sits between the PIM-consuming datapath engines and the my_pim hard block.

---
 rtl/pim_port_arbiter_pkg.sv | 24 ++
 rtl/pim_port_arbiter_if.sv | 35 +++
 rtl/pim_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/pim_port_arbiter.sv | 120 ++++++++++++
 tb/tb_pim_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_port_arbiter_pkg.sv
// rtl/pim_port_arbiter_pkg.sv - shared types and constants for the my_pim port arbiter
// Contents: OP_READ/OP_WRITE opcodes, FSM state enum, read-tag struct.
package pim_arb_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Tag index is sized for the largest supported requester count so the
    // struct stays non-parameterized; narrower builds zero-extend.
    localparam int NREQ_MAX  = 8;
    localparam int TAG_IDX_W = $clog2(NREQ_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/pim_port_arbiter_if.sv
// rtl/pim_port_arbiter_if.sv - requester/macro bus bundle for the my_pim port arbiter
// Signals: req_valid/req_we/req_addr/req_data/req_ready (command handshake),
//          drain/busy (control), pim_we/pim_addr/pim_data/pim_out (macro pins),
//          rsp_valid/rsp_data (read responses).
// slave modport: arbiter side; master modport: requesters plus macro.
interface pim_port_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 40,
    parameter int OUT_W  = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   drain;
    logic                   busy;
    logic                   pim_we;
    logic [ADDR_W-1:0]      pim_addr;
    logic [DATA_W-1:0]      pim_data;
    logic [OUT_W-1:0]       pim_out;
    logic [NREQ-1:0]        rsp_valid;
    logic [OUT_W-1:0]       rsp_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_data, drain, pim_out,
        output req_ready, busy, pim_we, pim_addr, pim_data, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_data, drain, pim_out,
        input  req_ready, busy, pim_we, pim_addr, pim_data, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pim_port_arbiter_rr_arbiter.sv
// rtl/pim_port_arbiter_rr_arbiter.sv - combinational round-robin picker
// Ports: i_req (request vector), i_ptr (highest-priority index),
//        o_gnt (one-hot grant), o_idx (encoded grant), o_any (some request won).
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_j;

    // Scan ptr, ptr+1, ... (mod NREQ); the first asserted request wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/pim_port_arbiter.sv
// rtl/pim_port_arbiter.sv - round-robin sharing of one my_pim macro port among NREQ requesters
// Ports: i_clk, i_reset (sync, active-high), bus (pim_port_arbiter_if.slave):
//        command handshake in, registered macro pins out, pim_out in,
//        one-hot read-response strobe and shared read data out, drain/busy control.
module pim_port_arbiter
    import pim_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 40,
    parameter int OUT_W    = 8,
    parameter int READ_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    pim_port_arbiter_if.slave  bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_pim_we;
    logic [ADDR_W-1:0]  r_pim_addr;
    logic [DATA_W-1:0]  r_pim_data;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [OUT_W-1:0]   r_rsp_data;
    // r_tag[k] is the tag of the read issued k+1 cycles ago; r_tag[READ_LAT]
    // lines up with pim_out for that read.
    tag_t               r_tag [0:READ_LAT];

    logic [NREQ-1:0]    w_gnt;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic               w_grant_en;
    logic               w_hs;
    logic               w_hs_we;
    logic               w_tags_busy;
    logic               w_pipe_empty;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(PTR_W)) u_rr (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    // The drain input blocks grants in the same cycle it rises; the DRAIN
    // state keeps blocking until in-flight work has left the pipeline.
    assign w_grant_en    = ~i_reset & ~bus.drain & (r_state != DRAIN);
    assign bus.req_ready = w_gnt & {NREQ{w_grant_en}};
    assign w_hs          = w_any & w_grant_en;
    assign w_hs_we       = bus.req_we[w_gnt_idx];

    always_comb begin
        w_tags_busy = 1'b0;
        for (int k = 0; k <= READ_LAT; k++) begin
            w_tags_busy = w_tags_busy | r_tag[k].valid;
        end
    end

    assign w_pipe_empty = ~r_pim_we & ~w_tags_busy;

    assign bus.busy      = r_pim_we | w_tags_busy | (r_state != IDLE);
    assign bus.pim_we    = r_pim_we;
    assign bus.pim_addr  = r_pim_addr;
    assign bus.pim_data  = r_pim_data;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_pim_we    <= 1'b0;
            r_pim_addr  <= '0;
            r_pim_data  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            for (int k = 0; k <= READ_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_pim_we <= w_hs & (w_hs_we == OP_WRITE);
            if (w_hs) begin
                r_pim_addr <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                if (w_hs_we == OP_WRITE) begin
                    r_pim_data <= bus.req_data[w_gnt_idx*DATA_W +: DATA_W];
                end
                r_ptr <= (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end

            r_tag[0].valid <= w_hs & (w_hs_we == OP_READ);
            r_tag[0].idx   <= TAG_IDX_W'(w_gnt_idx);
            for (int k = 1; k <= READ_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end

            if (r_tag[READ_LAT].valid) begin
                r_rsp_valid <= NREQ'(1) << r_tag[READ_LAT].idx;
                r_rsp_data  <= bus.pim_out;
            end else begin
                r_rsp_valid <= '0;
            end

            if (bus.drain) begin
                r_state <= DRAIN;
            end else begin
                case (r_state)
                    IDLE:    if (|bus.req_valid) r_state <= RUN;
                    RUN:     if (!(|bus.req_valid) && w_pipe_empty) r_state <= IDLE;
                    DRAIN:   if (w_pipe_empty) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pim_port_arbiter.sv
// tb/tb_pim_port_arbiter.sv - scoreboard bench for pim_port_arbiter (READ_LAT 1 and 3 builds)
module tb_pim_port_arbiter;
    import pim_arb_pkg::*;

    localparam int NREQ = 4, ADDR_W = 9, DATA_W = 40, OUT_W = 8;

    typedef struct {
        int         cyc;
        logic [3:0] v;
        logic [7:0] d;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [8:0]  a;
        logic [39:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    rsp_t rsp_q[$];
    rsp_t rsp3_q[$];
    wr_t  wr_q[$];

    logic [7:0] exp1 [512];
    logic [7:0] exp3 [512];
    logic [7:0] mem1 [512];
    logic [7:0] mem3 [512];
    logic [7:0] p1;
    logic [7:0] p3 [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pim_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();
    pim_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus3 ();

    pim_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .READ_LAT(1)) dut (
        .i_clk(clk), .i_reset(reset), .bus(bus.slave));
    pim_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .READ_LAT(3)) dut3 (
        .i_clk(clk), .i_reset(reset), .bus(bus3.slave));

    function automatic logic [7:0] init_val(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    // my_pim behavioural models: pins sampled at the edge, out READ_LAT edges later.
    always @(posedge clk) begin
        if (cyc < 2) begin
            for (int a = 0; a < 512; a++) mem1[a] <= init_val(a);
        end else if (bus.pim_we) begin
            mem1[bus.pim_addr] <= bus.pim_data[7:0];
        end
        p1 <= mem1[bus.pim_addr];
    end
    assign bus.pim_out = p1;

    always @(posedge clk) begin
        if (cyc < 2) begin
            for (int a = 0; a < 512; a++) mem3[a] <= init_val(a);
        end else if (bus3.pim_we) begin
            mem3[bus3.pim_addr] <= bus3.pim_data[7:0];
        end
        p3[0] <= mem3[bus3.pim_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus3.pim_out = p3[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic clr_all();
        bus.req_valid = '0;
        bus.req_we    = '0;
    endtask

    task automatic clr3();
        bus3.req_valid = '0;
        bus3.req_we    = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [8:0] a, input logic [39:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_we[i]    = we;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic set3(input int i, input logic we, input logic [8:0] a, input logic [39:0] d);
        bus3.req_valid[i] = 1'b1;
        bus3.req_we[i]    = we;
        bus3.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus3.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_rd(input int i, input logic [8:0] a);
        rsp_t e;
        e.cyc = cyc + 3;
        e.v   = 4'(1) << i;
        e.d   = exp1[a];
        rsp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [8:0] a, input logic [39:0] d);
        wr_t w;
        w.cyc = cyc + 1;
        w.a   = a;
        w.d   = d;
        wr_q.push_back(w);
        exp1[a] = d[7:0];
    endtask

    task automatic push3_rd(input int i, input logic [8:0] a);
        rsp_t e;
        e.cyc = cyc + 5;
        e.v   = 4'(1) << i;
        e.d   = exp3[a];
        rsp3_q.push_back(e);
    endtask

    // Response / macro-pin monitors, decoupled from stimulus.
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (cyc >= 2) begin
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                chk("rsp_missing", 64'(cyc), 64'(rsp_q[0].cyc));
                rsp_q.delete(0);
            end
            if (bus.rsp_valid !== '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.v));
                    chk("rsp_data", 64'(bus.rsp_data), 64'(e.d));
                end
            end
            if (bus.pim_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("pim_we_unexpected", 64'(bus.pim_we), 64'(0));
                end else begin
                    w = wr_q.pop_front();
                    chk("pim_cycle", 64'(cyc), 64'(w.cyc));
                    chk("pim_addr", 64'(bus.pim_addr), 64'(w.a));
                    chk("pim_data", 64'(bus.pim_data), 64'(w.d));
                end
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (cyc >= 2) begin
            while (rsp3_q.size() > 0 && rsp3_q[0].cyc < cyc) begin
                chk("l3_rsp_missing", 64'(cyc), 64'(rsp3_q[0].cyc));
                rsp3_q.delete(0);
            end
            if (bus3.rsp_valid !== '0) begin
                if (rsp3_q.size() == 0) begin
                    chk("l3_rsp_unexpected", 64'(bus3.rsp_valid), 64'(0));
                end else begin
                    e = rsp3_q.pop_front();
                    chk("l3_rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("l3_rsp_valid", 64'(bus3.rsp_valid), 64'(e.v));
                    chk("l3_rsp_data", 64'(bus3.rsp_data), 64'(e.d));
                end
            end
        end
    end

    logic [8:0] raddr [4];
    int         rr_order [5];

    initial begin
        for (int a = 0; a < 512; a++) begin
            exp1[a] = init_val(a);
            exp3[a] = init_val(a);
        end
        raddr    = '{9'h010, 9'h005, 9'h020, 9'h1FF};
        rr_order = '{0, 1, 2, 3, 0};
        bus.req_valid = '0;  bus.req_we = '0;  bus.req_addr = '0;  bus.req_data = '0;  bus.drain = 1'b0;
        bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_data = '0; bus3.drain = 1'b0;
        reset = 1'b1;

        // Reset state; grants suppressed while reset is high.
        step();
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
        chk("rst_pim_we", 64'(bus.pim_we), 64'(0));
        chk("rst_pim_addr", 64'(bus.pim_addr), 64'(0));
        chk("rst_pim_data", 64'(bus.pim_data), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_busy3", 64'(bus3.busy), 64'(0));

        // Single write at cycle 2.
        step();
        reset = 1'b0;
        clr_all();
        set_req(0, OP_WRITE, 9'h005, 40'h12_3456_789A);
        @(negedge clk);
        chk("wr_ready", 64'(bus.req_ready), 64'(4'b0001));
        push_wr(9'h005, 40'h12_3456_789A);
        step();
        clr_all();
        @(negedge clk);
        chk("wr_busy", 64'(bus.busy), 64'(1));
        step();
        @(negedge clk);
        chk("hold_we", 64'(bus.pim_we), 64'(0));
        chk("hold_addr", 64'(bus.pim_addr), 64'(9'h005));
        chk("hold_data", 64'(bus.pim_data), 64'(40'h12_3456_789A));

        // Single read by requester 2 at cycle 10 -> response at 13.
        wait_cyc(10);
        set_req(2, OP_READ, 9'h005, 40'h0);
        @(negedge clk);
        chk("rd_ready", 64'(bus.req_ready), 64'(4'b0100));
        push_rd(2, 9'h005);
        step();
        clr_all();
        wait_cyc(14);
        @(negedge clk);
        chk("rsp_data_hold", 64'(bus.rsp_data), 64'(8'h9A));
        chk("rsp_valid_low", 64'(bus.rsp_valid), 64'(0));

        // Move pointer to 0 with a write from requester 3, then all four read.
        wait_cyc(16);
        set_req(3, OP_WRITE, 9'h010, 40'hAB_0000_0055);
        @(negedge clk);
        chk("wr3_ready", 64'(bus.req_ready), 64'(4'b1000));
        push_wr(9'h010, 40'hAB_0000_0055);
        step();
        clr_all();
        for (int i = 0; i < 4; i++) set_req(i, OP_READ, raddr[i], 40'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", 64'(bus.req_ready), 64'(4'(1) << rr_order[k]));
            push_rd(rr_order[k], raddr[rr_order[k]]);
            step();
        end
        clr_all();

        // Drain with two reads in flight.
        wait_cyc(30);
        set_req(1, OP_READ, 9'h020, 40'h0);
        @(negedge clk);
        chk("dr_ready1", 64'(bus.req_ready), 64'(4'b0010));
        push_rd(1, 9'h020);
        step();
        clr_all();
        set_req(2, OP_READ, 9'h1FF, 40'h0);
        @(negedge clk);
        chk("dr_ready2", 64'(bus.req_ready), 64'(4'b0100));
        push_rd(2, 9'h1FF);
        step();
        clr_all();
        set_req(0, OP_READ, 9'h005, 40'h0);
        bus.drain = 1'b1;
        @(negedge clk);
        chk("drain_ready", 64'(bus.req_ready), 64'(0));
        chk("drain_busy", 64'(bus.busy), 64'(1));
        step();
        bus.drain = 1'b0;
        @(negedge clk);
        chk("drain_pend_ready", 64'(bus.req_ready), 64'(0));
        step();
        @(negedge clk);
        chk("drain_last_ready", 64'(bus.req_ready), 64'(0));
        chk("drain_last_busy", 64'(bus.busy), 64'(1));
        step();
        @(negedge clk);
        chk("busy_after_drain", 64'(bus.busy), 64'(0));
        chk("regrant_after_drain", 64'(bus.req_ready), 64'(4'b0001));
        push_rd(0, 9'h005);
        step();
        clr_all();

        // Reset with a read in flight: response must never appear.
        wait_cyc(42);
        set_req(1, OP_READ, 9'h010, 40'h0);
        @(negedge clk);
        chk("mid_ready", 64'(bus.req_ready), 64'(4'b0010));
        step();
        clr_all();
        reset = 1'b1;
        set_req(3, OP_READ, 9'h010, 40'h0);
        @(negedge clk);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
        step();
        @(negedge clk);
        chk("mid_pim_we", 64'(bus.pim_we), 64'(0));
        chk("mid_pim_addr", 64'(bus.pim_addr), 64'(0));
        chk("mid_pim_data", 64'(bus.pim_data), 64'(0));
        chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("mid_busy", 64'(bus.busy), 64'(0));
        step();
        reset = 1'b0;
        clr_all();

        // READ_LAT=3 build: read latency 5, then write/read to the same address.
        wait_cyc(55);
        set3(0, OP_READ, 9'h007, 40'h0);
        @(negedge clk);
        chk("l3_ready0", 64'(bus3.req_ready), 64'(4'b0001));
        push3_rd(0, 9'h007);
        step();
        clr3();
        wait_cyc(60);
        set3(1, OP_WRITE, 9'h007, 40'h00_0000_00C3);
        @(negedge clk);
        chk("l3_ready1", 64'(bus3.req_ready), 64'(4'b0010));
        exp3[9'h007] = 8'hC3;
        step();
        clr3();
        set3(2, OP_READ, 9'h007, 40'h0);
        @(negedge clk);
        chk("l3_ready2", 64'(bus3.req_ready), 64'(4'b0100));
        chk("l3_pim_we", 64'(bus3.pim_we), 64'(1));
        chk("l3_pim_addr", 64'(bus3.pim_addr), 64'(9'h007));
        push3_rd(2, 9'h007);
        step();
        clr3();

        wait_cyc(75);
        @(negedge clk);
        chk("rsp_q_left", 64'(rsp_q.size()), 64'(0));
        chk("wr_q_left", 64'(wr_q.size()), 64'(0));
        chk("l3_rsp_q_left", 64'(rsp3_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
